// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display prefetch into a small show-ahead pixel FIFO vs. an external writer.
// Optional build macro FB_DOUBLE_BUFFER_EN adds a second bank with frame-aligned display swap.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = 480000,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_WATER    = 8
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              FRAME_START,
  input  logic              PIX_POP,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_EMPTY,
  output logic              UNDERFLOW,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
`ifdef FB_DOUBLE_BUFFER_EN
  input  logic              SWAP_REQ,
  output logic              DISP_BANK,
  input  logic              WR_BANK,
  output logic [ADDR_W:0]   MEM_ADDR,
`else
  output logic [ADDR_W-1:0] MEM_ADDR,
`endif
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RDATA
);

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = PTR_W + 2;
  localparam logic [RES_W-1:0]  LOW_WATER_R = RES_W'(LOW_WATER);
  localparam logic [RES_W-1:0]  DEPTH_R     = RES_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   fetch_addr_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                rd_v1_reg;
  logic                rd_v2_reg;
  logic                underflow_reg;
  logic [MEM_AW-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                mem_we_reg;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic [RES_W-1:0]    res_occ;
  logic                grant_rd;
  logic                grant_wr;
  logic                fifo_empty;
  logic                push_en;
  logic                pop_en;
  logic                last_fetch;
  logic [MEM_AW-1:0]   rd_mem_addr;
  logic [MEM_AW-1:0]   wr_mem_addr;

  // Reads already in flight count against FIFO space so a returning word always has room.
  assign res_occ    = RES_W'(count_reg) + RES_W'(rd_v1_reg) + RES_W'(rd_v2_reg);
  assign fifo_empty = (count_reg == '0);
  assign push_en    = rd_v2_reg && !FRAME_START;
  assign pop_en     = PIX_POP && !fifo_empty && !FRAME_START;
  assign last_fetch = (fetch_addr_reg == LAST_ADDR);

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (RESET || FRAME_START) begin
      grant_rd = 1'b0;
    end else if (state_reg == ST_FILL && res_occ < LOW_WATER_R) begin
      grant_rd = 1'b1;
    end else if (WR_VALID) begin
      grant_wr = 1'b1;
    end else if (state_reg == ST_FILL && res_occ < DEPTH_R) begin
      grant_rd = 1'b1;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic swap_pend_reg;
  logic disp_bank_reg;

  // A requested swap waits for the frame boundary so a frame never mixes banks.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      swap_pend_reg <= 1'b0;
      disp_bank_reg <= 1'b0;
    end else if (FRAME_START) begin
      if (swap_pend_reg) begin
        disp_bank_reg <= ~disp_bank_reg;
      end
      swap_pend_reg <= SWAP_REQ;
    end else if (SWAP_REQ) begin
      swap_pend_reg <= 1'b1;
    end
  end

  assign DISP_BANK   = disp_bank_reg;
  assign rd_mem_addr = {disp_bank_reg, fetch_addr_reg};
  assign wr_mem_addr = {WR_BANK, WR_ADDR};
`else
  assign rd_mem_addr = fetch_addr_reg;
  assign wr_mem_addr = WR_ADDR;
`endif

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      fetch_addr_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rd_v1_reg      <= 1'b0;
      rd_v2_reg      <= 1'b0;
      underflow_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_we_reg     <= 1'b0;
    end else begin
      mem_we_reg <= grant_wr;
      if (grant_wr) begin
        mem_addr_reg  <= wr_mem_addr;
        mem_wdata_reg <= WR_DATA;
      end else if (grant_rd) begin
        mem_addr_reg  <= rd_mem_addr;
      end

      if (PIX_POP && fifo_empty && !FRAME_START) begin
        underflow_reg <= 1'b1;
      end

      if (FRAME_START) begin
        // Flush: in-flight returns are dropped by clearing their valids.
        state_reg      <= ST_FILL;
        fetch_addr_reg <= '0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
        rd_v1_reg      <= 1'b0;
        rd_v2_reg      <= 1'b0;
      end else begin
        rd_v1_reg <= grant_rd;
        rd_v2_reg <= rd_v1_reg;
        if (grant_rd) begin
          if (last_fetch) begin
            state_reg <= ST_DONE;
          end else begin
            fetch_addr_reg <= fetch_addr_reg + ADDR_W'(1);
          end
        end
        if (push_en) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop_en) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        case ({push_en, pop_en})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (push_en) begin
      fifo_mem[wr_ptr_reg] <= MEM_RDATA;
    end
  end

  // Reservation makes a push into a full FIFO impossible; flag it if it ever happens.
  always_ff @(posedge VGA_CLK) begin
    if (!RESET && push_en && !pop_en) begin
      assert (count_reg != DEPTH_C);
    end
  end

  assign PIX_DATA  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign PIX_EMPTY = fifo_empty;
  assign UNDERFLOW = underflow_reg;
  assign WR_READY  = WR_VALID && grant_wr;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;
  assign MEM_WE    = mem_we_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: per-cycle vector table plus sequences for
// underflow, in-flight flush, reset and (with FB_DOUBLE_BUFFER_EN) bank swap.
module tb_vga_fb_arbiter;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 12;
  localparam int FRAME_PIXELS = 20;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif
  localparam int WADDR = 600;
  localparam int WDATA = 'hABC;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_start;
  logic              pix_pop;
  logic [DATA_W-1:0] pix_data;
  logic              pix_empty;
  logic              underflow;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
`ifdef FB_DOUBLE_BUFFER_EN
  logic              swap_req;
  logic              disp_bank;
  logic              wr_bank;
`endif

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FRAME_PIXELS),
    .FIFO_DEPTH(16), .LOW_WATER(8)
  ) dut (
    .VGA_CLK(clk), .RESET(reset), .FRAME_START(frame_start), .PIX_POP(pix_pop),
    .PIX_DATA(pix_data), .PIX_EMPTY(pix_empty), .UNDERFLOW(underflow),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
`ifdef FB_DOUBLE_BUFFER_EN
    .SWAP_REQ(swap_req), .DISP_BANK(disp_bank), .WR_BANK(wr_bank),
`endif
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we), .MEM_RDATA(mem_rdata)
  );

  // Image RAM holds RAM[i] = i; the writer only targets an address far above the fetched region.
  always @(posedge clk) begin
    mem_rdata <= DATA_W'(mem_addr[ADDR_W-1:0]);
  end

  typedef struct {
    logic fs;
    logic pop;
    logic wv;
    logic exp_we;
    int   exp_addr;
    logic exp_rdy;
    logic exp_empty;
    int   exp_data;
  } vec_t;

  vec_t vecs [64];
  int   n_vecs = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add_vec(input logic fs, input logic pop, input logic wv, input logic we,
                         input int addr, input logic rdy, input logic empty, input int data);
    vecs[n_vecs].fs        = fs;
    vecs[n_vecs].pop       = pop;
    vecs[n_vecs].wv        = wv;
    vecs[n_vecs].exp_we    = we;
    vecs[n_vecs].exp_addr  = addr;
    vecs[n_vecs].exp_rdy   = rdy;
    vecs[n_vecs].exp_empty = empty;
    vecs[n_vecs].exp_data  = data;
    n_vecs++;
  endtask

  task automatic check(input string what, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got 0x%0h, want 0x%0h", what, idx, act, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic step(input logic fs, input logic pop, input logic wv);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    frame_start = fs;
    pix_pop     = pop;
    wr_valid    = wv;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pix_pop = 1'b0; wr_valid = 1'b1;
    wr_addr = ADDR_W'(WADDR); wr_data = DATA_W'(WDATA);
`ifdef FB_DOUBLE_BUFFER_EN
    swap_req = 1'b0; wr_bank = 1'b0;
`endif

    // Fill with no pops, then pop every cycle with the writer always requesting.
    add_vec(1, 0, 0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 2; k <= 17; k++) add_vec(0, 0, 0, 0, k - 2, 0, (k < 4), 0);
    add_vec(0, 0, 0, 0, 15, 0, 0, 0);
    for (int c = 19; c <= 38; c++) begin
      logic we;
      int   addr;
      we   = (c >= 20 && c <= 28) || (c >= 33);
      addr = we ? WADDR : ((c == 19) ? 15 : c - 13);
      add_vec(0, 1, 1, we, addr, (c <= 27) || (c >= 32), 0, c - 19);
    end
    add_vec(0, 0, 1, 1, WADDR, 1, 1, 0);
    add_vec(0, 0, 0, 1, WADDR, 0, 1, 0);
    add_vec(0, 0, 0, 0, WADDR, 0, 1, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", -1, int'(wr_ready), 0);
    check("rst_mem_we", -1, int'(mem_we), 0);
    check("rst_mem_addr", -1, int'(mem_addr), 0);
    check("rst_mem_wdata", -1, int'(mem_wdata), 0);
    check("rst_pix_empty", -1, int'(pix_empty), 1);
    check("rst_pix_data", -1, int'(pix_data), 0);
    check("rst_underflow", -1, int'(underflow), 0);

    for (int i = 0; i < n_vecs; i++) begin
      step(vecs[i].fs, vecs[i].pop, vecs[i].wv);
      $display("vec %0d fs=%0b pop=%0b wv=%0b we=%0b addr=%0d rdy=%0b empty=%0b data=%03h",
               i, frame_start, pix_pop, wr_valid, mem_we, mem_addr, wr_ready, pix_empty, pix_data);
      check("mem_we", i, int'(mem_we), int'(vecs[i].exp_we));
      check("mem_addr", i, int'(mem_addr), vecs[i].exp_addr);
      if (vecs[i].exp_we) check("mem_wdata", i, int'(mem_wdata), WDATA);
      check("wr_ready", i, int'(wr_ready), int'(vecs[i].exp_rdy));
      check("pix_empty", i, int'(pix_empty), int'(vecs[i].exp_empty));
      check("pix_data", i, int'(pix_data), vecs[i].exp_data);
      check("underflow", i, int'(underflow), 0);
    end

    // Pop on an empty FIFO right after a frame start; the flag is sticky across frames.
    step(1, 0, 0);
    step(0, 1, 0);
    check("uf_before", 100, int'(underflow), 0);
    check("uf_empty", 100, int'(pix_empty), 1);
    step(0, 0, 0);
    check("uf_set", 101, int'(underflow), 1);
    check("uf_data", 101, int'(pix_data), 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("uf_sticky", 102, int'(underflow), 1);
    $display("seq underflow done uf=%0b", underflow);

    // Frame start while two reads are outstanding: both returns must be dropped.
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("flush_empty0", 200, int'(pix_empty), 1);
    step(0, 0, 0);
    check("flush_empty1", 201, int'(pix_empty), 1);
    step(0, 0, 0);
    check("flush_empty2", 202, int'(pix_empty), 1);
    step(0, 1, 0);
    check("flush_ready", 203, int'(pix_empty), 0);
    check("flush_head0", 203, int'(pix_data), 0);
    step(0, 1, 0);
    check("flush_head1", 204, int'(pix_data), 1);
    step(0, 0, 0);
    check("flush_head2", 205, int'(pix_data), 2);
    $display("seq flush done data=%03h", pix_data);

    // Reset clears the sticky flag and gates the writer.
    @(posedge clk);
    #1;
    reset = 1'b1; wr_valid = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_underflow", 300, int'(underflow), 0);
    check("rst2_empty", 300, int'(pix_empty), 1);
    check("rst2_wr_ready", 300, int'(wr_ready), 0);
    check("rst2_mem_we", 300, int'(mem_we), 0);
    $display("seq reset done uf=%0b", underflow);

`ifdef FB_DOUBLE_BUFFER_EN
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    #1 swap_req = 1'b1;
    step(0, 0, 1);
    #1 swap_req = 1'b0;
    step(0, 0, 1);
    check("db_bank_pending", 400, int'(disp_bank), 0);
    step(1, 0, 1);
    check("db_bank_at_fs", 401, int'(disp_bank), 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1);
      if (k == 1) check("db_bank_toggled", 402, int'(disp_bank), 1);
      if (k == 2) check("db_read_addr", 403, int'(mem_addr), (1 << ADDR_W));
      if (k == 8) check("db_rdy_low", 404, int'(wr_ready), 0);
      if (k == 9) check("db_rdy_high", 405, int'(wr_ready), 1);
      if (k == 10) begin
        check("db_wr_we", 406, int'(mem_we), 1);
        check("db_wr_addr", 406, int'(mem_addr), WADDR);
      end
    end
    $display("seq double-buffer done bank=%0b", disp_bank);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two users:
  - display prefetch, which fills a small pixel FIFO that feeds the VGA timing generator;
  - an external pixel writer, such as a drawing engine.
- Display fetch gets urgent priority whenever the FIFO runs low. Otherwise the writer wins.
- Sits between the framebuffer RAM and the VGA timing generator, in the VGA_CLK domain.

Parameters:
- ADDR_W, 19, framebuffer word address width (800x600 = 480000 words)
- DATA_W, 12, pixel width (4R,4G,4B, R in MSBs)
- FRAME_PIXELS, 480000, words fetched per frame, from address 0 upward
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
- LOW_WATER, 8, urgency threshold on reserved occupancy

Ports:
- VGA_CLK  in  1  pixel clock, rising edge
- RESET  in  1  synchronous, active-high
- FRAME_START  in  1  one-cycle pulse before first visible pixel of a frame
- PIX_POP  in  1  timing generator consumes head pixel this cycle
- PIX_DATA  out  DATA_W  FIFO head (show-ahead); 0 when empty
- PIX_EMPTY  out  1  FIFO empty
- UNDERFLOW  out  1  sticky: pop while empty
- WR_VALID  in  1  writer request
- WR_READY  out  1  writer granted this cycle
- WR_ADDR  in  ADDR_W  write address
- WR_DATA  in  DATA_W  write pixel
- MEM_ADDR  out  ADDR_W  RAM address (registered)
- MEM_WDATA  out  DATA_W  RAM write data (registered)
- MEM_WE  out  1  RAM write enable (registered)
- MEM_RDATA  in  DATA_W  RAM read data, valid cycle after address

Behaviour:
- Reset state:
  - FSM = IDLE; fetch_addr = 0; FIFO empty.
  - In-flight valids = 0; UNDERFLOW = 0.
  - MEM_ADDR = 0, MEM_WDATA = 0, MEM_WE = 0; WR_READY = 0; PIX_DATA = 0; PIX_EMPTY = 1.
- FSM:
  - IDLE -> FILL on FRAME_START.
  - FILL -> DONE when the read of address FRAME_PIXELS-1 is granted.
  - DONE -> FILL on FRAME_START.
  - FRAME_START in any state:
    - fetch_addr = 0, FIFO flushed;
    - both in-flight read valids cleared, so returning data is discarded;
    - UNDERFLOW unaffected.
- Reserved occupancy: res = fifo_count + rd_v1 + rd_v2, where rd_v1/rd_v2 is the 2-stage read pipeline.
- Grant decision, combinational each cycle, first match wins:
  1. FRAME_START: no grant.
  2. FILL and res < LOW_WATER: read.
  3. WR_VALID: write, WR_READY = 1.
  4. FILL and res < FIFO_DEPTH: read.
  5. Otherwise idle.
- WR_READY is only asserted when WR_VALID is high and grant 3 applies. Transfer = WR_VALID & WR_READY.
- Write grant in cycle t:
  - MEM_WE = 1, MEM_ADDR = WR_ADDR, MEM_WDATA = WR_DATA during cycle t+1;
  - MEM_WE = 0 otherwise.
- Read grant in cycle t:
  - MEM_ADDR = fetch_addr during t+1; fetch_addr increments; rd_v1 set.
  - MEM_RDATA is sampled at the end of t+2 and pushed to the FIFO (rd_v2).
  - Grant-to-PIX_DATA latency = 3 cycles.
- Reservation guarantees push never finds the FIFO full. Overflow is a verification assertion, not handled.
- Pop and push in the same cycle: count unchanged; head advances.
- PIX_POP with FIFO empty:
  - no state change, PIX_DATA stays 0;
  - UNDERFLOW set, cleared only by RESET.
- FRAME_START and PIX_POP in the same cycle: the flush wins and the pop is ignored.
- No read/write coherency: a write to an address already fetched this frame appears next frame.
- fetch_addr never exceeds FRAME_PIXELS-1. In DONE no reads are issued and the writer gets every cycle.

Optional Feature:
FB_DOUBLE_BUFFER_EN
- Defined:
  - Adds input SWAP_REQ (1), output DISP_BANK (1, reset 0) and input WR_BANK (1).
  - MEM_ADDR widens to ADDR_W+1, with MSB = bank.
  - Reads use DISP_BANK; writes use WR_BANK.
  - SWAP_REQ sets a pending flag. At the next FRAME_START, DISP_BANK toggles and the flag clears. The toggle takes effect on that frame's first read.
- Undefined: single bank, no extra ports, MEM_ADDR is ADDR_W wide.

Test Plan:
- RESET high 2 cycles, then FRAME_START with RAM[i] = i, no PIX_POP -> exactly 16 reads issued (addresses 0..15), PIX_EMPTY falls 3 cycles after first grant, PIX_DATA = 0x000.
- Steady pops every cycle plus WR_VALID held high:
  - writer granted only while res >= 8;
  - popped sequence 0,1,2,... with no UNDERFLOW.
- Pops start 1 cycle after FRAME_START (FIFO empty) -> UNDERFLOW = 1 and stays 1 through the next FRAME_START; cleared only by RESET.
- FRAME_START asserted while 2 reads are in flight -> both returns discarded, next PIX_DATA = RAM[0], count = 0 immediately after flush.
- FRAME_PIXELS = 20, continuous pops -> FSM enters DONE after address 19, no further MEM reads, WR_READY = WR_VALID every cycle.
- With FB_DOUBLE_BUFFER_EN: SWAP_REQ pulse mid-frame -> DISP_BANK toggles 0 to 1 at the next FRAME_START; reads then use MEM_ADDR MSB = 1; writes with WR_BANK = 0 use MSB = 0.
